mem_responder: RTL and testbench

Memory-side responder for the CPU's memory bus: accepts `mem_cmd`/`mem_addr`/`write_data` from the CPU, services them from a 256-word RAM and a small memory-mapped I/O window, and returns `read_data` with a one-cycle `mem_ready` strobe after a programmable number of wait states. It sits between `cpu` and the board I/O: switches on the input side, LEDs on the output side.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_responder_if.sv | 19 +
 rtl/mem_ram256.sv | 25 ++
 rtl/mem_responder.sv | 163 ++++++++++++++++
 tb/tb_mem_responder.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the CPU memory bus: command and FSM encodings plus
// the address-map constants used by mem_responder and the cpu.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b10
    } mem_cmd_t;

    typedef enum logic [1:0] {
        MEM_ST_IDLE = 2'd0,
        MEM_ST_WAIT = 2'd1,
        MEM_ST_RESP = 2'd2
    } mem_state_t;

    localparam logic [8:0] MEM_LED_ADDR = 9'h100;
    localparam logic [8:0] MEM_SW_ADDR  = 9'h140;
    localparam logic [8:0] MEM_RAM_TOP  = 9'h0FF;

    // True when a word address falls inside the 256-word RAM.
    function automatic logic mem_is_ram(input logic [8:0] addr);
        return addr <= MEM_RAM_TOP;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU memory bus: command/address/data from the CPU (master), load data and
// a one-cycle ready strobe back from the memory responder (slave).
interface mem_responder_if;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        mem_ready;

    modport master (
        output mem_cmd, mem_addr, write_data,
        input  read_data, mem_ready
    );

    modport slave (
        input  mem_cmd, mem_addr, write_data,
        output read_data, mem_ready
    );
endinterface

// File: rtl/mem_ram256.sv
// 256x16 single-port RAM with synchronous write and registered read.
// Neither the array nor the read register is reset, so it maps onto block RAM.
module mem_ram256 (
    input  logic        clk,
    input  logic        we,
    input  logic        re,
    input  logic [7:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata
);
    logic [15:0] mem_q [256];
    logic [15:0] rdata_q;

    // Write and read are each enabled only on the commit edge of a command.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: services CPU bus READ/WRITE commands from a 256-word
// RAM and a small I/O window after WAIT_CYCLES wait states, then strobes
// mem_ready for one cycle.
// Optional feature: define MEM_IO_EN to decode the LED register (0x100) and
// the switch port (0x140); otherwise all of 0x100-0x1FF is unmapped.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_responder_if.slave    bus,
    input  logic [7:0]        sw_in,
    output logic [7:0]        led_out
);
    localparam logic [1:0] S_IDLE = MEM_ST_IDLE;
    localparam logic [1:0] S_WAIT = MEM_ST_WAIT;
    localparam logic [1:0] S_RESP = MEM_ST_RESP;

    // Counter preload; unused when there are no wait states.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [8:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        src_ram_q, src_ram_d;
    logic [15:0] io_rdata_q, io_rdata_d;
    logic [7:0]  led_q, led_d;

    logic        bus_valid;
    logic        commit;
    logic [1:0]  commit_cmd;
    logic [8:0]  commit_addr;
    logic [15:0] commit_wdata;
    logic        commit_rd, commit_wr, commit_ram;
    logic        ram_we, ram_re;
    logic [15:0] ram_rdata;

    assign bus_valid = (bus.mem_cmd == MEM_READ) || (bus.mem_cmd == MEM_WRITE);

    // Sequencing: accept in IDLE, count wait states, respond for one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus_valid) begin
                    cmd_d   = bus.mem_cmd;
                    addr_d  = bus.mem_addr;
                    wdata_d = bus.write_data;
                    cnt_d   = WAIT_LOAD;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // With no wait states the commit edge is the acceptance edge, so the
    // live bus values are used; otherwise the captured copies are.
    always_comb begin
        commit_cmd   = (state_q == S_IDLE) ? bus.mem_cmd    : cmd_q;
        commit_addr  = (state_q == S_IDLE) ? bus.mem_addr   : addr_q;
        commit_wdata = (state_q == S_IDLE) ? bus.write_data : wdata_q;
    end

    assign commit_rd  = commit && (commit_cmd == MEM_READ);
    assign commit_wr  = commit && (commit_cmd == MEM_WRITE);
    assign commit_ram = mem_is_ram(commit_addr);
    // The RAM has no reset, so block any access while reset is held.
    assign ram_we     = commit_wr && commit_ram && !reset;
    assign ram_re     = commit_rd && commit_ram && !reset;

    mem_ram256 u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (commit_addr[7:0]),
        .wdata (commit_wdata),
        .rdata (ram_rdata)
    );

    // Load-data source select, I/O read register and LED register updates.
    always_comb begin
        src_ram_d  = src_ram_q;
        io_rdata_d = io_rdata_q;
        led_d      = led_q;
        if (commit_rd) begin
            src_ram_d  = commit_ram;
            io_rdata_d = 16'h0000;
`ifdef MEM_IO_EN
            if (commit_addr == MEM_LED_ADDR) begin
                io_rdata_d = {8'h00, led_q};
            end else if (commit_addr == MEM_SW_ADDR) begin
                io_rdata_d = {8'h00, sw_in};
            end
`endif
        end
`ifdef MEM_IO_EN
        if (commit_wr && (commit_addr == MEM_LED_ADDR)) begin
            led_d = commit_wdata[7:0];
        end
`endif
    end

`ifndef MEM_IO_EN
    // Switches are not decoded in this build.
    logic unused_sw;
    assign unused_sw = ^sw_in;
`endif

    // State and output registers; reset aborts any command in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            cmd_q      <= MEM_NONE;
            addr_q     <= 9'h000;
            wdata_q    <= 16'h0000;
            src_ram_q  <= 1'b0;
            io_rdata_q <= 16'h0000;
            led_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            src_ram_q  <= src_ram_d;
            io_rdata_q <= io_rdata_d;
            led_q      <= led_d;
        end
    end

    assign bus.mem_ready = (state_q == S_RESP);
    assign bus.read_data = src_ram_q ? ram_rdata : io_rdata_q;
    assign led_out       = led_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances with 0, 1 and 3 wait
// states share clock, reset and switches; each has its own bus interface.
module tb_mem_responder;
    import mem_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sw_in;
    logic [7:0] led0, led1, led3;
    int         tests = 0;
    int         fails = 0;
    logic [15:0] rdv;
    logic [7:0]  led3_exp;

    mem_responder_if bus0 ();
    mem_responder_if bus1 ();
    mem_responder_if bus3 ();

    mem_responder #(.WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .reset(reset), .bus(bus0.slave), .sw_in(sw_in), .led_out(led0));
    mem_responder #(.WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .reset(reset), .bus(bus1.slave), .sw_in(sw_in), .led_out(led1));
    mem_responder #(.WAIT_CYCLES(3)) dut_w3 (
        .clk(clk), .reset(reset), .bus(bus3.slave), .sw_in(sw_in), .led_out(led3));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int idx, input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        case (idx)
            0:       begin bus0.mem_cmd = c; bus0.mem_addr = a; bus0.write_data = d; end
            1:       begin bus1.mem_cmd = c; bus1.mem_addr = a; bus1.write_data = d; end
            default: begin bus3.mem_cmd = c; bus3.mem_addr = a; bus3.write_data = d; end
        endcase
    endtask

    function automatic logic get_rdy(input int idx);
        case (idx)
            0:       return bus0.mem_ready;
            1:       return bus1.mem_ready;
            default: return bus3.mem_ready;
        endcase
    endfunction

    function automatic logic [15:0] get_rd(input int idx);
        case (idx)
            0:       return bus0.read_data;
            1:       return bus1.read_data;
            default: return bus3.read_data;
        endcase
    endfunction

    // One transaction: drive at a falling edge, count rising edges until
    // mem_ready, optionally disturb addr/data during the first wait cycle,
    // then drop the command and confirm the strobe lasted one cycle.
    task automatic issue(input int idx, input logic [1:0] c, input logic [8:0] a,
                         input logic [15:0] d, input int exp_lat, input bit do_alt,
                         input logic [8:0] alt_a, input logic [15:0] alt_d,
                         output logic [15:0] rd);
        int lat;
        bit seen;
        @(negedge clk);
        drive(idx, c, a, d);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (get_rdy(idx)) seen = 1'b1;
            else if (do_alt && lat == 1) drive(idx, c, alt_a, alt_d);
        end
        chk($sformatf("latency dut%0d cmd%0d addr%0h", idx, c, a), seen ? lat : -1, exp_lat);
        rd = get_rd(idx);
        drive(idx, MEM_NONE, 9'h000, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("ready_pulse dut%0d addr%0h", idx, a), {31'd0, get_rdy(idx)}, 0);
        $display("[TB] dut%0d cmd=%0d addr=%03h wdata=%04h lat=%0d rdata=%04h", idx, c, a, d, lat, rd);
    endtask

    task automatic op(input int idx, input logic [1:0] c, input logic [8:0] a,
                      input logic [15:0] d, input int exp_lat, output logic [15:0] rd);
        issue(idx, c, a, d, exp_lat, 1'b0, 9'h000, 16'h0000, rd);
    endtask

    initial begin
        reset = 1'b1;
        sw_in = 8'h00;
        drive(0, MEM_NONE, 9'h000, 16'h0000);
        drive(1, MEM_NONE, 9'h000, 16'h0000);
        drive(3, MEM_NONE, 9'h000, 16'h0000);
        repeat (2) @(negedge clk);
        chk("reset ready0", {31'd0, bus0.mem_ready}, 0);
        chk("reset ready1", {31'd0, bus1.mem_ready}, 0);
        chk("reset ready3", {31'd0, bus3.mem_ready}, 0);
        chk("reset rdata0", bus0.read_data, 16'h0000);
        chk("reset rdata1", bus1.read_data, 16'h0000);
        chk("reset rdata3", bus3.read_data, 16'h0000);
        chk("reset led0", led0, 8'h00);
        chk("reset led1", led1, 8'h00);
        chk("reset led3", led3, 8'h00);
        reset = 1'b0;

        // One wait state: basic write/read, capture behaviour, hold behaviour.
        op(1, MEM_WRITE, 9'h005, 16'hBEEF, 2, rdv);
        op(1, MEM_READ,  9'h005, 16'h0000, 2, rdv);
        chk("read 005", rdv, 16'hBEEF);
        op(1, MEM_WRITE, 9'h021, 16'h1234, 2, rdv);
        issue(1, MEM_WRITE, 9'h020, 16'hAAAA, 2, 1'b1, 9'h021, 16'h5555, rdv);
        op(1, MEM_READ,  9'h021, 16'h0000, 2, rdv);
        chk("captured write kept 021", rdv, 16'h1234);
        op(1, MEM_READ,  9'h020, 16'h0000, 2, rdv);
        chk("captured write hit 020", rdv, 16'hAAAA);
        issue(1, MEM_READ, 9'h005, 16'h0000, 2, 1'b1, 9'h020, 16'h0000, rdv);
        chk("captured read addr", rdv, 16'hBEEF);
        op(1, MEM_WRITE, 9'h030, 16'h0000, 2, rdv);
        chk("read_data held over write", bus1.read_data, 16'hBEEF);

        // I/O window.
        sw_in = 8'h3C;
`ifdef MEM_IO_EN
        op(1, MEM_WRITE, 9'h100, 16'h12A5, 2, rdv);
        chk("led after write", led1, 8'hA5);
        op(1, MEM_READ,  9'h100, 16'h0000, 2, rdv);
        chk("read led reg", rdv, 16'h00A5);
        op(1, MEM_READ,  9'h140, 16'h0000, 2, rdv);
        chk("read switches", rdv, 16'h003C);
        op(1, MEM_WRITE, 9'h140, 16'hFFFF, 2, rdv);
        chk("led after sw write", led1, 8'hA5);
`else
        op(1, MEM_WRITE, 9'h100, 16'h00FF, 2, rdv);
        chk("led unmapped", led1, 8'h00);
        op(1, MEM_READ,  9'h140, 16'h0000, 2, rdv);
        chk("read switches unmapped", rdv, 16'h0000);
`endif
        op(1, MEM_READ,  9'h005, 16'h0000, 2, rdv);
        chk("reread 005", rdv, 16'hBEEF);
        op(1, MEM_READ,  9'h1FF, 16'h0000, 2, rdv);
        chk("read 1FF", rdv, 16'h0000);

        // Zero wait states: back-to-back reads with the command held.
        op(0, MEM_WRITE, 9'h000, 16'h1357, 1, rdv);
        op(0, MEM_WRITE, 9'h0FF, 16'h2468, 1, rdv);
        @(negedge clk);
        drive(0, MEM_READ, 9'h000, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        chk("b2b first ready", {31'd0, bus0.mem_ready}, 1);
        chk("b2b first data", bus0.read_data, 16'h1357);
        drive(0, MEM_READ, 9'h0FF, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        chk("b2b gap ready", {31'd0, bus0.mem_ready}, 0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b second ready", {31'd0, bus0.mem_ready}, 1);
        chk("b2b second data", bus0.read_data, 16'h2468);
        drive(0, MEM_NONE, 9'h000, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        chk("b2b end ready", {31'd0, bus0.mem_ready}, 0);
        $display("[TB] dut0 back-to-back reads 000/0FF done");

        // Three wait states: reset during the second wait cycle of a write.
        op(3, MEM_WRITE, 9'h010, 16'h2222, 4, rdv);
        op(3, MEM_READ,  9'h010, 16'h0000, 4, rdv);
        chk("read 010 before abort", rdv, 16'h2222);
`ifdef MEM_IO_EN
        op(3, MEM_WRITE, 9'h100, 16'h0077, 4, rdv);
        led3_exp = 8'h77;
`else
        led3_exp = 8'h00;
`endif
        chk("led3 before abort", led3, led3_exp);
        @(negedge clk);
        drive(3, MEM_WRITE, 9'h010, 16'h1111);
        @(posedge clk);
        @(negedge clk);
        chk("abort wait1 ready", {31'd0, bus3.mem_ready}, 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        drive(3, MEM_NONE, 9'h000, 16'h0000);
        #1;
        chk("abort reset ready3", {31'd0, bus3.mem_ready}, 0);
        chk("abort reset rdata3", bus3.read_data, 16'h0000);
        chk("abort reset led3", led3, 8'h00);
        chk("abort reset rdata1", bus1.read_data, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("in reset ready3 %0d", i), {31'd0, bus3.mem_ready}, 0);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("post reset ready3 %0d", i), {31'd0, bus3.mem_ready}, 0);
        end
        $display("[TB] dut3 write 010<=1111 aborted by reset");
        op(3, MEM_READ, 9'h010, 16'h0000, 4, rdv);
        chk("read 010 after abort", rdv, 16'h2222);
        chk("led3 after abort", led3, 8'h00);
        op(1, MEM_READ, 9'h005, 16'h0000, 2, rdv);
        chk("ram kept over reset", rdv, 16'hBEEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
